// File: rtl/sinc3_pkg.sv
// sinc3_pkg
//   Shared definitions for the sinc3 filter sequencer: controller state
//   encoding, the mode value driven out of reset, and the counter widths.
package sinc3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_e;

  localparam logic [1:0]  MODE_RST = 2'd3;
  localparam int unsigned FLUSH_W  = 8;
  localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/sinc3_out_reg.sv
// sinc3_out_reg
//   One-entry valid/ready holding register for decimated samples, with a
//   sticky overrun flag set when a new sample arrives while the held one is
//   still unconsumed.
// Ports
//   clk_i      in  1   clock, rising edge
//   rst_i      in  1   synchronous reset, active-high
//   load_i     in  1   new sample offered this cycle
//   data_i     in  DW  sample offered with load_i
//   ready_i    in  1   consumer accepts when valid_o & ready_i
//   clr_ovr_i  in  1   clears the overrun flag
//   data_o     out DW  held sample
//   valid_o    out 1   data_o valid
//   overrun_o  out 1   sticky: a sample was dropped
module sinc3_out_reg #(
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  input  logic          clr_ovr_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          overrun_o
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load_i) begin
      // A sample leaving this cycle frees the slot for the incoming one.
      if (!valid_q || ready_i) begin
        data_d  = data_i;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/sinc3_ctrl.sv
// sinc3_ctrl
//   Sequencer for the sinc3 decimation filter. Programs the filter MODE,
//   holds the filter in reset for FLUSH_CYC cycles on start or mode change,
//   discards the first SETTLE_N ENBL rising edges while the filter settles,
//   then forwards each decimated SNCOUT word through a valid/ready register.
//   Optional burst mode (macro SINC3_CTRL_BURST_EN): acquisition returns to
//   IDLE after BURST_LEN loaded samples.
// Ports
//   MCLK      in  1   clock, rising edge
//   RST       in  1   synchronous reset, active-high
//   cfg_mode  in  2   decimation mode to apply
//   cfg_load  in  1   pulse: latch cfg_mode, re-flush if not IDLE
//   start     in  1   pulse: begin acquisition from IDLE
//   stop      in  1   pulse: abort to IDLE
//   MODE      out 2   registered mode to sinc3
//   FLT_RST   out 1   filter reset, active-low
//   ENBL      in  1   sinc3 output-ready level
//   SNCOUT    in  DW  sinc3 output word, valid on ENBL rising edge
//   smp_data  out DW  held sample
//   smp_valid out 1   smp_data valid
//   smp_ready in  1   consumer ready
//   overrun   out 1   sticky sample-dropped flag
//   busy      out 1   state != IDLE
module sinc3_ctrl
  import sinc3_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned FLUSH_CYC = 4,
  parameter int unsigned SETTLE_N  = 3,
  parameter int unsigned BURST_LEN = 256
) (
  input  logic          MCLK,
  input  logic          RST,
  input  logic [1:0]    cfg_mode,
  input  logic          cfg_load,
  input  logic          start,
  input  logic          stop,
  output logic [1:0]    MODE,
  output logic          FLT_RST,
  input  logic          ENBL,
  input  logic [DW-1:0] SNCOUT,
  output logic [DW-1:0] smp_data,
  output logic          smp_valid,
  input  logic          smp_ready,
  output logic          overrun,
  output logic          busy
);

  if (FLUSH_CYC < 1 || FLUSH_CYC > 255 || SETTLE_N > 15 ||
      BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_param
    $error("sinc3_ctrl: parameter out of range");
  end

  localparam logic [FLUSH_W-1:0]  FLUSH_INIT  = FLUSH_W'(FLUSH_CYC - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_N);

  state_e               state_q, state_d;
  logic [FLUSH_W-1:0]   cnt_q, cnt_d;
  logic [SETTLE_W-1:0]  scnt_q, scnt_d;
  logic [1:0]           mode_q, mode_d;
  logic                 enbl_q;
  logic                 rise;
  logic                 start_acc;
  logic                 run_load;
  logic                 clr_ovr;
  logic                 burst_done;

  assign rise = ENBL & ~enbl_q;

  // stop and cfg_load both outrank start and rise in the same cycle.
  assign start_acc = start & ~stop & ~cfg_load & (state_q == IDLE);
  assign run_load  = rise & ~stop & ~cfg_load & (state_q == RUN);
  assign clr_ovr   = ~stop & (cfg_load | start_acc);

`ifdef SINC3_CTRL_BURST_EN
  localparam logic [8:0] BURST_LAST = 9'(BURST_LEN - 1);

  logic [8:0] burst_q, burst_d;
  logic       loaded;

  // Only samples that actually enter the output register are counted.
  assign loaded     = run_load & (~smp_valid | smp_ready);
  assign burst_done = loaded & (burst_q == BURST_LAST);

  always_comb begin
    burst_d = burst_q;
    if (start_acc) begin
      burst_d = '0;
    end else if (loaded) begin
      burst_d = burst_q + 9'd1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign burst_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    mode_d  = mode_q;
    if (stop) begin
      state_d = IDLE;
    end else if (cfg_load) begin
      mode_d = cfg_mode;
      if (state_q != IDLE) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_INIT;
      end
    end else if (start_acc) begin
      state_d = FLUSH;
      cnt_d   = FLUSH_INIT;
    end else begin
      unique case (state_q)
        FLUSH: begin
          if (cnt_q == '0) begin
            if (SETTLE_N == 0) begin
              state_d = RUN;
            end else begin
              state_d = SETTLE;
              scnt_d  = SETTLE_INIT;
            end
          end else begin
            cnt_d = cnt_q - FLUSH_W'(1);
          end
        end
        SETTLE: begin
          // Leave on the last discarded rise so the next rise is delivered.
          if (scnt_q == '0) begin
            state_d = RUN;
          end else if (rise) begin
            scnt_d = scnt_q - SETTLE_W'(1);
            if (scnt_q == SETTLE_W'(1)) begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (burst_done) begin
            state_d = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scnt_q  <= '0;
      mode_q  <= MODE_RST;
      enbl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      mode_q  <= mode_d;
      enbl_q  <= ENBL;
    end
  end

  sinc3_out_reg #(
    .DW(DW)
  ) u_out_reg (
    .clk_i     (MCLK),
    .rst_i     (RST),
    .load_i    (run_load),
    .data_i    (SNCOUT),
    .ready_i   (smp_ready),
    .clr_ovr_i (clr_ovr),
    .data_o    (smp_data),
    .valid_o   (smp_valid),
    .overrun_o (overrun)
  );

  assign MODE    = mode_q;
  assign FLT_RST = (state_q == SETTLE) || (state_q == RUN);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sinc3_ctrl.sv
module tb_sinc3_ctrl;

  localparam int unsigned DW = 16;

  logic          MCLK = 1'b0;
  logic          RST = 1'b1;
  logic [1:0]    cfg_mode = 2'd0;
  logic          cfg_load = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    MODE;
  logic          FLT_RST;
  logic          ENBL = 1'b0;
  logic [DW-1:0] SNCOUT = '0;
  logic [DW-1:0] smp_data;
  logic          smp_valid;
  logic          smp_ready = 1'b0;
  logic          overrun;
  logic          busy;

  int total = 0;
  int bad = 0;

  sinc3_ctrl #(
    .DW(DW),
    .FLUSH_CYC(4),
    .SETTLE_N(3),
    .BURST_LEN(4)
  ) dut (
    .MCLK(MCLK), .RST(RST), .cfg_mode(cfg_mode), .cfg_load(cfg_load),
    .start(start), .stop(stop), .MODE(MODE), .FLT_RST(FLT_RST),
    .ENBL(ENBL), .SNCOUT(SNCOUT), .smp_data(smp_data), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .overrun(overrun), .busy(busy)
  );

  always #5 MCLK = ~MCLK;

  task automatic cyc;
    @(posedge MCLK);
    #1;
  endtask

  task automatic wait_flush(output int n);
    n = 0;
    while (!FLT_RST && n < 40) begin
      n++;
      cyc();
    end
  endtask

  task automatic pulse_rise(input logic [DW-1:0] d);
    ENBL = 1'b1;
    SNCOUT = d;
    cyc();
    ENBL = 1'b0;
  endtask

  task automatic acquire;
    int n;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_flush(n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL acq_flush_cycles got=%0d want=4", n); end
    for (int i = 0; i < 3; i++) begin
      pulse_rise(16'h0F00 + 16'(i));
      cyc();
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
    total++;
    if (MODE !== 2'd3) begin bad++; $display("FAIL rst_mode got=%0d want=3", MODE); end
    total++;
    if (FLT_RST !== 1'b0) begin bad++; $display("FAIL rst_flt got=%0b want=0", FLT_RST); end
    total++;
    if (smp_data !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h want=0000", smp_data); end
    total++;
    if (smp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", smp_valid); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%0b want=0", overrun); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
  endtask

  task automatic test_settle;
    int n;
    cfg_mode = 2'd1;
    cfg_load = 1'b1;
    cyc();
    cfg_load = 1'b0;
    total++;
    if (MODE !== 2'd1) begin bad++; $display("FAIL idle_cfg_mode got=%0d want=1", MODE); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_cfg_busy got=%0b want=0", busy); end
    smp_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_flush(n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL flush_cycles got=%0d want=4", n); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL settle_busy got=%0b want=1", busy); end
    for (int i = 0; i < 3; i++) begin
      pulse_rise(16'h0101 * 16'(i + 1));
      total++;
      if (smp_valid !== 1'b0) begin bad++; $display("FAIL discard_%0d got=%0b want=0", i, smp_valid); end
      cyc();
    end
    pulse_rise(16'h1234);
    total++;
    if (smp_data !== 16'h1234) begin bad++; $display("FAIL first_data got=%h want=1234", smp_data); end
    total++;
    if (smp_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b want=1", smp_valid); end
    cyc();
    total++;
    if (smp_valid !== 1'b0) begin bad++; $display("FAIL first_consumed got=%0b want=0", smp_valid); end
  endtask

  task automatic test_overrun;
    smp_ready = 1'b0;
    pulse_rise(16'hAAAA);
    total++;
    if (smp_data !== 16'hAAAA) begin bad++; $display("FAIL ovr_first got=%h want=aaaa", smp_data); end
    cyc();
    pulse_rise(16'hBBBB);
    total++;
    if (smp_data !== 16'hAAAA) begin bad++; $display("FAIL ovr_hold got=%h want=aaaa", smp_data); end
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%0b want=1", overrun); end
    cyc();
    smp_ready = 1'b1;
    pulse_rise(16'hCCCC);
    smp_ready = 1'b0;
    total++;
    if (smp_data !== 16'hCCCC) begin bad++; $display("FAIL accept_load_data got=%h want=cccc", smp_data); end
    total++;
    if (smp_valid !== 1'b1) begin bad++; $display("FAIL accept_load_valid got=%0b want=1", smp_valid); end
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b want=1", overrun); end
    cyc();
  endtask

  task automatic test_cfg_reload;
    int n;
    cfg_mode = 2'd2;
    cfg_load = 1'b1;
    pulse_rise(16'hDDDD);
    cfg_load = 1'b0;
    total++;
    if (MODE !== 2'd2) begin bad++; $display("FAIL reload_mode got=%0d want=2", MODE); end
    total++;
    if (FLT_RST !== 1'b0) begin bad++; $display("FAIL reload_flt got=%0b want=0", FLT_RST); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL reload_ovr_clr got=%0b want=0", overrun); end
    total++;
    if (smp_data !== 16'hCCCC) begin bad++; $display("FAIL reload_no_load got=%h want=cccc", smp_data); end
    smp_ready = 1'b1;
    wait_flush(n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL reload_flush_cycles got=%0d want=4", n); end
    total++;
    if (smp_valid !== 1'b0) begin bad++; $display("FAIL reload_drain got=%0b want=0", smp_valid); end
    for (int i = 0; i < 3; i++) begin
      pulse_rise(16'h1111 * 16'(i + 1));
      total++;
      if (smp_valid !== 1'b0) begin bad++; $display("FAIL reload_discard_%0d got=%0b want=0", i, smp_valid); end
      cyc();
    end
    pulse_rise(16'h4444);
    total++;
    if (smp_data !== 16'h4444) begin bad++; $display("FAIL reload_data got=%h want=4444", smp_data); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL reload_ovr got=%0b want=0", overrun); end
    cyc();
  endtask

  task automatic test_stop;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL stop_idle got=%0b want=0", busy); end
    acquire();
    smp_ready = 1'b0;
    pulse_rise(16'h5555);
    cyc();
    total++;
    if (smp_data !== 16'h5555) begin bad++; $display("FAIL stop_pending got=%h want=5555", smp_data); end
    stop = 1'b1;
    pulse_rise(16'h6666);
    stop = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%0b want=0", busy); end
    total++;
    if (FLT_RST !== 1'b0) begin bad++; $display("FAIL stop_flt got=%0b want=0", FLT_RST); end
    total++;
    if (smp_data !== 16'h5555) begin bad++; $display("FAIL stop_rise_ignored got=%h want=5555", smp_data); end
    total++;
    if (smp_valid !== 1'b1) begin bad++; $display("FAIL stop_keep_valid got=%0b want=1", smp_valid); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL stop_ovr got=%0b want=0", overrun); end
    smp_ready = 1'b1;
    cyc();
    total++;
    if (smp_valid !== 1'b0) begin bad++; $display("FAIL stop_delivered got=%0b want=0", smp_valid); end
    pulse_rise(16'h7777);
    total++;
    if (smp_valid !== 1'b0) begin bad++; $display("FAIL idle_rise got=%0b want=0", smp_valid); end
    cyc();
  endtask

`ifdef SINC3_CTRL_BURST_EN
  task automatic test_burst;
    int delivered;
    logic [DW-1:0] last;
    delivered = 0;
    last = '0;
    smp_ready = 1'b1;
    acquire();
    for (int i = 0; i < 6; i++) begin
      pulse_rise(16'hB000 + 16'(i));
      if (smp_valid) begin
        delivered++;
        last = smp_data;
      end
      cyc();
    end
    total++;
    if (delivered !== 4) begin bad++; $display("FAIL burst_count got=%0d want=4", delivered); end
    total++;
    if (last !== 16'hB003) begin bad++; $display("FAIL burst_last got=%h want=b003", last); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL burst_busy got=%0b want=0", busy); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_settle();
    test_overrun();
    test_cfg_reload();
    test_stop();
`ifdef SINC3_CTRL_BURST_EN
    test_burst();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
